alu_bus_unit: RTL and testbench

- Datapath slice for the 8-bit accumulator CPU: a combinational ALU plus the 8-way bus source multiplexer.
- The CPU control FSM drives the bus select and ALU opcode every cycle. The register file feeds the mux sources and ALU operands.
- A small flag register captures ALU status on command; it is the only clocked state in the block.

---
 rtl/alu_bus_unit.sv | 60 ++++++
 tb/tb_alu_bus_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_bus_unit.sv
// alu_bus_unit: 8-way bus source mux, combinational ALU and registered C/Z/N/V status flags
module alu_bus_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] src3,
  input  logic [WIDTH-1:0] src4,
  input  logic [WIDTH-1:0] src5,
  input  logic [WIDTH-1:0] src6,
  input  logic [WIDTH-1:0] src7,
  input  logic [2:0]       bus_slct,
  output logic [WIDTH-1:0] bus_out,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_out,
  input  logic             flag_we,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);
  localparam int M = WIDTH - 1;
  logic [WIDTH-1:0] srcs [8];
  logic             c, v;
  assign srcs = '{src0, src1, src2, src3, src4, src5, src6, src7};
  assign bus_out = srcs[bus_slct];
  always_comb begin
    alu_out = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_op)
      3'd0: begin
        {c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        v = (alu_a[M] == alu_b[M]) && (alu_out[M] != alu_a[M]);
      end
      3'd1: begin
        {c, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
        v = (alu_a[M] != alu_b[M]) && (alu_out[M] != alu_a[M]);
      end
      3'd2: alu_out = alu_b;
      3'd3: alu_out = alu_a & alu_b;
      3'd4: alu_out = alu_a | alu_b;
      3'd5: alu_out = alu_a ^ alu_b;
      3'd6: begin
        {c, alu_out} = {1'b0, alu_a} + {{WIDTH{1'b0}}, 1'b1};
        v = ~alu_a[M] & alu_out[M];
      end
      3'd7: alu_out = ~alu_a;
      default: alu_out = 'x;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {flag_c, flag_z, flag_n, flag_v} <= 4'b0000;
    else if (flag_we) {flag_c, flag_z, flag_n, flag_v} <= {c, alu_out == '0, alu_out[M], v};
endmodule

// File: tb/tb_alu_bus_unit.sv
// tb_alu_bus_unit: directed test-plan steps then random operations against an arithmetic reference model
module tb_alu_bus_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] src [8];
  logic [2:0] bus_slct = '0;
  logic [7:0] bus_out, alu_a = '0, alu_b_drv = '0, alu_out;
  logic [2:0] alu_op = '0;
  logic       flag_we = 1'b0, use_bus = 1'b0;
  logic       flag_c, flag_z, flag_n, flag_v;
  logic [7:0] alu_b;
  int         errs = 0, checks = 0;
  assign alu_b = use_bus ? bus_out : alu_b_drv;
  always #5 clk = ~clk;
  alu_bus_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .src0(src[0]), .src1(src[1]), .src2(src[2]), .src3(src[3]),
    .src4(src[4]), .src5(src[5]), .src6(src[6]), .src7(src[7]),
    .bus_slct(bus_slct), .bus_out(bus_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .flag_we(flag_we), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );
  // returns {result[7:0], C, Z, N, V} derived from integer arithmetic
  function automatic logic [11:0] model(input int a, input int b, input int op);
    int r, s, sa, sb;
    logic c, v;
    sa = a > 127 ? a - 256 : a;
    sb = b > 127 ? b - 256 : b;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      0: begin r = a + b; c = r > 255; s = sa + sb; v = s > 127 || s < -128; end
      1: begin r = a - b; c = a < b; s = sa - sb; v = s > 127 || s < -128; end
      2: r = b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin r = a + 1; c = r > 255; s = sa + 1; v = s > 127; end
      default: r = 255 - a;
    endcase
    r = r & 255;
    return {r[7:0], c, r == 0, r[7], v};
  endfunction
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] flags();
    return {4'b0000, flag_c, flag_z, flag_n, flag_v};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op_step(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] exp_out, input logic [3:0] exp_f);
    alu_a = a; alu_b_drv = b; alu_op = op; flag_we = 1'b1;
    #1 check({tag, "_out"}, alu_out, exp_out);
    tick();
    check({tag, "_flags"}, flags(), {4'b0000, exp_f});
    flag_we = 1'b0;
  endtask
  initial begin
    logic [11:0] m;
    logic [3:0]  ef;
    logic [7:0]  hold;
    foreach (src[i]) src[i] = 8'((i + 1) * 8'h11);
    #2 check("reset_flags", flags(), 8'h00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_slct = 3'(i);
      #1 check($sformatf("mux_%0d", i), bus_out, 8'((i + 1) * 8'h11));
    end
    src[7] = 8'h00;
    #1 check("mux_const0", bus_out, 8'h00);
    op_step("add_ff_01", 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1100);
    op_step("add_7f_01", 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0011);
    op_step("sub_03_05", 8'h03, 8'h05, 3'd1, 8'hFE, 4'b1010);
    op_step("sub_80_01", 8'h80, 8'h01, 3'd1, 8'h7F, 4'b0001);
    op_step("pass_07", 8'h00, 8'h07, 3'd2, 8'h07, 4'b0000);
    op_step("and", 8'hF0, 8'h3C, 3'd3, 8'h30, 4'b0000);
    op_step("or", 8'hF0, 8'h3C, 3'd4, 8'hFC, 4'b0010);
    op_step("xor", 8'hF0, 8'h3C, 3'd5, 8'hCC, 4'b0010);
    op_step("not", 8'hF0, 8'h3C, 3'd7, 8'h0F, 4'b0000);
    op_step("inc_ff", 8'hFF, 8'h00, 3'd6, 8'h00, 4'b1100);
    op_step("inc_7f", 8'h7F, 8'h00, 3'd6, 8'h80, 4'b0011);
    op_step("hold_set", 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1100);
    alu_a = 8'h7F; alu_b_drv = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_%0d", i), flags(), 8'h0C);
    end
    flag_we = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_reset", flags(), 8'h00);
    alu_a = 8'hFF; alu_b_drv = 8'h01;
    tick();
    tick();
    check("reset_dominates_we", flags(), 8'h00);
    flag_we = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("release_no_we", flags(), 8'h00);
    flag_we = 1'b1;
    tick();
    check("first_capture", flags(), 8'h0C);
    flag_we = 1'b0;
    src[2] = alu_out; src[3] = 8'h07; bus_slct = 3'd3; use_bus = 1'b1; alu_op = 3'd2;
    #1 check("lda_bus", bus_out, 8'h07);
    check("lda_alu", alu_out, 8'h07);
    use_bus = 1'b0;
    ef = 4'b1100;
    for (int k = 0; k < 300; k++) begin
      foreach (src[i]) src[i] = 8'($urandom);
      bus_slct = 3'($urandom);
      alu_a = 8'($urandom);
      alu_b_drv = k % 5 == 0 ? alu_a : 8'($urandom);
      alu_op = 3'($urandom);
      flag_we = 1'($urandom);
      m = model(int'(alu_a), int'(alu_b_drv), int'(alu_op));
      hold = src[bus_slct];
      #1 check("rnd_bus", bus_out, hold);
      check($sformatf("rnd_alu_op%0d", alu_op), alu_out, m[11:4]);
      if (flag_we) ef = m[3:0];
      tick();
      check($sformatf("rnd_flags_op%0d", alu_op), flags(), {4'b0000, ef});
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
